micro_sequencer: RTL

Hardwired fetch/decode/execute sequencer for the 8-bit processor.
- Drives the SZ-bit control-word bus consumed by the datapath: ALU op strobes, register in/out enables, MAR/MBR/IR strobes, PC controls, WMFC, rnw and endd.
- Decodes ins = {opcode[7:4], rd[3:2], rs[1:0]} from IR.
- Stalls on memory through the WMFC/MFC handshake.

---
 rtl/seq_pkg.sv | 69 ++++++
 rtl/reg_sel_dec.sv | 10 +
 rtl/micro_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the micro-sequencer and the control unit:
// control-word bit indices, opcodes and the 4-bit state encoding.
package seq_pkg;

  localparam int CW_BITS = 23;

  localparam int CB_ADD            = 0;
  localparam int CB_COMP           = 1;
  localparam int CB_SUB            = 2;
  localparam int CB_XORR           = 3;
  localparam int CB_ANDD           = 4;
  localparam int CB_ORR            = 5;
  localparam int CB_PC_OUT         = 6;
  localparam int CB_INCREMENT      = 7;
  localparam int CB_WMFC           = 8;
  localparam int CB_RNW            = 9;
  localparam int CB_A_IN           = 10;
  localparam int CB_B_IN           = 11;
  localparam int CB_C_IN           = 12;
  localparam int CB_D_IN           = 13;
  localparam int CB_A_OUT          = 14;
  localparam int CB_B_OUT          = 15;
  localparam int CB_C_OUT          = 16;
  localparam int CB_D_OUT          = 17;
  localparam int CB_MAR_IN         = 18;
  localparam int CB_MBR_OUT        = 19;
  localparam int CB_IR_IN          = 20;
  localparam int CB_SELECT_DECODER = 21;
  localparam int CB_ENDD           = 22;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_CMP  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_F0    = 4'd1,
    S_F1    = 4'd2,
    S_F2    = 4'd3,
    S_DEC   = 4'd4,
    S_E1    = 4'd5,
    S_E2    = 4'd6,
    S_END   = 4'd7,
    S_HALT  = 4'd8,
    S_FAULT = 4'd9
  } state_t;

  function automatic logic [CW_BITS-1:0] alu_op_bit(input logic [3:0] opcode);
    logic [CW_BITS-1:0] r;
    r = '0;
    case (opcode)
      OP_ADD:  r[CB_ADD]  = 1'b1;
      OP_SUB:  r[CB_SUB]  = 1'b1;
      OP_AND:  r[CB_ANDD] = 1'b1;
      OP_OR:   r[CB_ORR]  = 1'b1;
      OP_XOR:  r[CB_XORR] = 1'b1;
      OP_CMP:  r[CB_COMP] = 1'b1;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reg_sel_dec.sv
// 2-bit register select plus enable to one-hot A/B/C/D strobe.
module reg_sel_dec (
  input  logic [1:0] i_sel,
  input  logic       i_en,
  output logic [3:0] o_onehot
);

  assign o_onehot = i_en ? (4'b0001 << i_sel) : 4'b0000;

endmodule

// File: rtl/micro_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the datapath control word.
// Optional MFC wait timeout with FAULT state: define MFC_TIMEOUT_EN.
//
// state   | meaning
// RESET   | idle after reset, control word all zero
// F0      | PC to MAR, start read, increment PC
// F1      | wait for memory (WMFC) until MFC
// F2      | MBR to IR
// DEC     | decode ins
// E1      | rd onto bus, ALU latches first operand
// E2      | rs onto bus, ALU op / move, write rd
// END     | end of instruction
// HALT    | halted until reset
// FAULT   | memory timeout, stuck until reset
module micro_sequencer
  import seq_pkg::*;
#(
  parameter int SZ      = 23,
  parameter int TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [7:0]    ins,
  input  logic          MFC,
  output logic [SZ-1:0] CS_bus,
  output logic          halted,
  output logic          fault
);

  if (SZ < CW_BITS || TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_param
    $error("micro_sequencer: SZ must be >= 23 and TIMEOUT in 1..15");
  end

  state_t r_state;
  state_t w_next;

  logic [3:0]         w_opcode;
  logic [1:0]         w_rd;
  logic [1:0]         w_rs;
  logic               w_is_alu;
  logic               w_is_mov;
  logic               w_timeout;
  logic               w_rd_in_en;
  logic [3:0]         w_rd_in;
  logic [3:0]         w_rd_out;
  logic [3:0]         w_rs_out;
  logic [CW_BITS-1:0] w_cw;

  assign w_opcode = ins[7:4];
  assign w_rd     = ins[3:2];
  assign w_rs     = ins[1:0];
  assign w_is_alu = (w_opcode >= OP_ADD) && (w_opcode <= OP_CMP);
  assign w_is_mov = (w_opcode == OP_MOV);

`ifdef MFC_TIMEOUT_EN
  logic [3:0] r_wait_cnt;

  // Counter is zero outside F1, so it is already clear on F1 entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_F1 && !MFC) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == S_F1) && !MFC && (r_wait_cnt == 4'(TIMEOUT - 1));
  assign fault     = (r_state == S_FAULT);
`else
  assign w_timeout = 1'b0;
  assign fault     = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET: w_next = S_F0;
      S_F0:    w_next = S_F1;
      S_F1: begin
        if (MFC) begin
          w_next = S_F2;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_F2:    w_next = S_DEC;
      S_DEC: begin
        if (w_is_alu) begin
          w_next = S_E1;
        end else if (w_is_mov) begin
          w_next = S_E2;
        end else if (w_opcode == OP_HALT) begin
          w_next = S_HALT;
        end else begin
          w_next = S_END;
        end
      end
      S_E1:    w_next = S_E2;
      S_E2:    w_next = S_END;
      S_END:   w_next = S_F0;
      S_HALT:  w_next = S_HALT;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_RESET;
    endcase
  end

  assign w_rd_in_en = (r_state == S_E2) && (w_is_mov || (w_is_alu && w_opcode != OP_CMP));

  reg_sel_dec u_rd_in  (.i_sel(w_rd), .i_en(w_rd_in_en),          .o_onehot(w_rd_in));
  reg_sel_dec u_rd_out (.i_sel(w_rd), .i_en(r_state == S_E1),     .o_onehot(w_rd_out));
  reg_sel_dec u_rs_out (.i_sel(w_rs), .i_en(r_state == S_E2),     .o_onehot(w_rs_out));

  always_comb begin
    w_cw = '0;
    case (r_state)
      S_F0: begin
        w_cw[CB_PC_OUT]    = 1'b1;
        w_cw[CB_MAR_IN]    = 1'b1;
        w_cw[CB_RNW]       = 1'b1;
        w_cw[CB_INCREMENT] = 1'b1;
      end
      S_F1: begin
        w_cw[CB_WMFC] = 1'b1;
        w_cw[CB_RNW]  = 1'b1;
      end
      S_F2: begin
        w_cw[CB_MBR_OUT] = 1'b1;
        w_cw[CB_IR_IN]   = 1'b1;
      end
      S_E1:    w_cw[CB_SELECT_DECODER] = 1'b1;
      S_E2:    w_cw = alu_op_bit(w_opcode);
      S_END:   w_cw[CB_ENDD] = 1'b1;
      S_HALT:  w_cw[CB_ENDD] = 1'b1;
      default: w_cw = '0;
    endcase
    // Register strobes are gated by state inside the decoders.
    w_cw[CB_D_IN:CB_A_IN]   = w_rd_in;
    w_cw[CB_D_OUT:CB_A_OUT] = w_rd_out | w_rs_out;
  end

  always_comb begin
    CS_bus              = '0;
    CS_bus[CW_BITS-1:0] = w_cw;
  end

  assign halted = (r_state == S_HALT);

endmodule
